jmax_min_scheduler: RTL

//  Sequencer that time-shares one external 4-bit magnitude comparator
//  (EQ/GT/LT outputs) to find the max and min of a frame of N samples.

---
 rtl/jmax_min_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/jmax_min_scheduler.sv
// Frame max/min finder that time-shares one external magnitude comparator:
// each sample after the first costs a max compare and then a min compare.
module jmax_min_scheduler #(
  parameter  int WIDTH = 4,
  parameter  int N     = 8,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IW-1:0]    max_idx,
  output logic [IW-1:0]    min_idx,
  output logic             busy,
  output logic             done,
  output logic             cmp_err
);

  localparam logic [IW:0] LAST_CNT = (IW+1)'(N);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRST   = 3'd1,
    S_FETCH   = 3'd2,
    S_CMP_MAX = 3'd3,
    S_CMP_MIN = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] cmp_a_q;
  logic [WIDTH-1:0] cmp_b_q;
  logic [IW-1:0]    max_idx_q;
  logic [IW-1:0]    min_idx_q;
  logic [IW:0]      count_q;
  logic [IW:0]      count_d;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             cmp_err_q;
  logic             flags_bad_s;

  // A healthy comparator raises exactly one of its three flags.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    return ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) || ({eq, gt, lt} == 3'b001);
  endfunction

  assign count_d     = count_q + {{IW{1'b0}}, 1'b1};
  assign flags_bad_s = !flags_onehot(cmp_eq, cmp_gt, cmp_lt);

  // Sequencer; all outputs are registered and loaded alongside the state move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sample_q   <= {WIDTH{1'b0}};
      max_q      <= {WIDTH{1'b0}};
      min_q      <= {WIDTH{1'b0}};
      cmp_a_q    <= {WIDTH{1'b0}};
      cmp_b_q    <= {WIDTH{1'b0}};
      max_idx_q  <= {IW{1'b0}};
      min_idx_q  <= {IW{1'b0}};
      count_q    <= {(IW+1){1'b0}};
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmp_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FIRST;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            cmp_err_q  <= 1'b0;
            count_q    <= {(IW+1){1'b0}};
          end
        end
        S_FIRST: begin
          if (in_valid) begin
            max_q     <= in_data;
            min_q     <= in_data;
            max_idx_q <= {IW{1'b0}};
            min_idx_q <= {IW{1'b0}};
            count_q   <= {{IW{1'b0}}, 1'b1};
            if (N == 1) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            sample_q   <= in_data;
            cmp_a_q    <= in_data;
            cmp_b_q    <= max_q;
            in_ready_q <= 1'b0;
            state_q    <= S_CMP_MAX;
          end
        end
        S_CMP_MAX: begin
          // Strictly greater only, so ties keep the earliest index.
          if (cmp_gt) begin
            max_q     <= sample_q;
            max_idx_q <= count_q[IW-1:0];
          end
          if (flags_bad_s) begin
            cmp_err_q <= 1'b1;
          end
          cmp_b_q <= min_q;
          state_q <= S_CMP_MIN;
        end
        S_CMP_MIN: begin
          if (cmp_lt) begin
            min_q     <= sample_q;
            min_idx_q <= count_q[IW-1:0];
          end
          if (flags_bad_s) begin
            cmp_err_q <= 1'b1;
          end
          count_q <= count_d;
          cmp_a_q <= {WIDTH{1'b0}};
          cmp_b_q <= {WIDTH{1'b0}};
          if (count_d == LAST_CNT) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_FETCH;
            in_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cmp_a_q    <= {WIDTH{1'b0}};
          cmp_b_q    <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign cmp_a    = cmp_a_q;
  assign cmp_b    = cmp_b_q;
  assign max_val  = max_q;
  assign min_val  = min_q;
  assign max_idx  = max_idx_q;
  assign min_idx  = min_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cmp_err  = cmp_err_q;

endmodule
